register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-port register file for the MIPS datapath. It is the successor to the fixed 32x32, 2-read/1-write file.
- Configurable data width, depth, read-port count and write-port count.
- Synchronous reset, followed by a hardware init sweep.
- Optional hard-wired zero register and deterministic write-collision priority.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
INIT_MODE, 1, init sweep value: 0 = all zeros, 1 = entry k loaded with k (zero-extended)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
init_busy  out  1  high during reset and the init sweep
w_address_s_N  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
w_data_sval_N  out  NUM_RD*DATA_W  packed read data; port i is bits [i*DATA_W +: DATA_W]
w_en_N  in  NUM_WR  per-port write enable
w_address_d_N  in  NUM_WR*ADDR_W  packed write addresses
w_data_dval_N  in  NUM_WR*DATA_W  packed write data

Behaviour:
- One clock domain: clock. reset is synchronous and active-high, sampled on the rising edge of clock.
- FSM states: RST, INIT, READY.
  - RST: entered on any edge where reset=1, from any state, including mid-INIT. Sweep counter cleared to 0. init_busy=1.
  - RST -> INIT on the first edge with reset=0.
  - INIT: each cycle writes the init value (per INIT_MODE) to entry[cnt], then cnt++. Exactly DEPTH cycles.
  - INIT -> READY on the edge that writes entry DEPTH-1. init_busy drops in the cycle after the last init write.
  - READY: normal operation. No exit except reset.
- During RST and INIT:
  - all w_en_N are ignored;
  - all read data outputs drive 0.
- Reads are combinational (zero latency) in READY: w_data_sval_N[i] = entry[addr_i].
- Writes in READY: on a rising edge, every port with w_en_N[j]=1 writes its data to entry[w_address_d_N[j]]. Data is visible to reads in the following cycle.
- Collision: if two write ports target the same address in one cycle, port NUM_WR-1 (highest index) wins. The other write is dropped silently.
- ZERO_REG=1:
  - reads of address 0 return 0;
  - writes to address 0 are discarded;
  - the INIT sweep still runs DEPTH cycles.
- ZERO_REG=0: entry 0 behaves like any other entry.
- Reset mid-operation: contents are re-initialised by the sweep. No entry value survives a reset.
- Width rule: in INIT_MODE=1, the index is truncated to DATA_W if ADDR_W > DATA_W.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: in READY, a read whose address matches an active write this cycle returns that write's data combinationally (write-through). The collision priority rule applies when several writes match. ZERO_REG still forces address 0 to 0.
- Undefined: same-cycle reads return the pre-write (old) value. The new value appears in the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - state enum (ST_RST, ST_INIT, ST_READY);
  - INIT_ZERO / INIT_INDEX constants;
  - a localparam function computing DEPTH from ADDR_W.
- One natural sub-module, regfile_rd_port: one read mux, including the bypass compare and zero-reg masking. Instantiated NUM_RD times via generate.

Test Plan:
- Reset then init: hold reset 3 cycles, release, INIT_MODE=1, DEPTH=32 -> init_busy high for exactly 32 cycles after release. Afterwards reading addr 5 gives 0x00000005 and addr 31 gives 0x0000001F.
- Basic write/read: in READY, write 0xDEADBEEF to addr 7 -> next cycle w_data_sval port0 (addr 7) = 0xDEADBEEF, and port1 (addr 6) = 0x00000006.
- Zero register: ZERO_REG=1, write 0x12345678 to addr 0 -> a read of addr 0 returns 0x00000000 forever after.
- Dual-write collision: NUM_WR=2, port0 writes 0xAAAA0000 and port1 writes 0x5555FFFF to addr 9 in the same cycle -> addr 9 reads 0x5555FFFF.
- Same-cycle read of written address: write 0xCAFEF00D to addr 3 while reading addr 3:
  - REGFILE_BYPASS_EN defined -> reads 0xCAFEF00D in the same cycle;
  - undefined -> reads 0x00000003, then 0xCAFEF00D the next cycle.
- Reset mid-init: assert reset at init cycle 10 for 1 cycle -> the sweep restarts, init_busy stays high 32 more cycles, and a write attempted during init (addr 4, 0xFFFFFFFF) is ignored, so addr 4 reads 0x00000004.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the multi-port MIPS register file.
//   state_t    : controller states (reset, init sweep, ready)
//   INIT_ZERO  : init sweep loads every entry with zero
//   INIT_INDEX : init sweep loads entry k with k
//   depth_of() : number of entries for a given address width
// ----------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_INIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   localparam int INIT_ZERO  = 0;
   localparam int INIT_INDEX = 1;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// ----------------------------------------------------------------------------
// regfile_rd_port
// One combinational read port of the register file.
// Optional macro: REGFILE_BYPASS_EN (same-cycle write-through on reads).
// Ports:
//   i_ready    : controller in READY; when low the port drives zero
//   i_rd_addr  : read address
//   i_mem      : full register array
//   i_wr_en    : write enables        (bypass build only)
//   i_wr_addr  : packed write addresses (bypass build only)
//   i_wr_data  : packed write data    (bypass build only)
//   o_rd_data  : read data
// ----------------------------------------------------------------------------
module regfile_rd_port #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                                     i_ready,
   input  logic [ADDR_W-1:0]                        i_rd_addr,
   input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]       i_mem,
`ifdef REGFILE_BYPASS_EN
   input  logic [NUM_WR-1:0]                        i_wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]                 i_wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]                 i_wr_data,
`endif
   output logic [DATA_W-1:0]                        o_rd_data
);

   logic [DATA_W-1:0] w_data;

   always_comb begin
      w_data = i_mem[i_rd_addr];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan: a later (higher-index) matching port overrides,
      // matching the write-collision priority of the array itself.
      for (int j = 0; j < NUM_WR; j++) begin
         if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr))
            w_data = i_wr_data[j*DATA_W +: DATA_W];
      end
`endif
      if (!i_ready || ((ZERO_REG != 0) && (i_rd_addr == '0)))
         w_data = '0;
   end

   assign o_rd_data = w_data;

endmodule

// File: rtl/register_file_mp.sv
// ----------------------------------------------------------------------------
// register_file_mp
// Parametrised multi-port register file with synchronous reset followed by a
// hardware init sweep over all DEPTH entries.
// Optional macro: REGFILE_BYPASS_EN (reads see same-cycle writes).
// Ports:
//   clock          : system clock, rising edge
//   reset          : synchronous active-high reset
//   init_busy      : high while in reset or during the init sweep
//   w_address_s_N  : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   w_data_sval_N  : packed read data,      port i at [i*DATA_W +: DATA_W]
//   w_en_N         : per-port write enables
//   w_address_d_N  : packed write addresses
//   w_data_dval_N  : packed write data
// ----------------------------------------------------------------------------
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   parameter int ZERO_REG  = 1,
   parameter int INIT_MODE = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       init_busy,
   input  logic [NUM_RD*ADDR_W-1:0]   w_address_s_N,
   output logic [NUM_RD*DATA_W-1:0]   w_data_sval_N,
   input  logic [NUM_WR-1:0]          w_en_N,
   input  logic [NUM_WR*ADDR_W-1:0]   w_address_d_N,
   input  logic [NUM_WR*DATA_W-1:0]   w_data_dval_N
);

   localparam int DEPTH = depth_of(ADDR_W);

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [ADDR_W-1:0]               r_cnt;
   logic [DEPTH-1:0][DATA_W-1:0]    r_mem;
   logic                            w_ready;
   logic                            w_busy;
   logic [DATA_W+ADDR_W-1:0]        w_cnt_ext;
   logic [DATA_W-1:0]               w_init_val;

   // ---------------- controller FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_RST;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_ready     = 1'b0;
      case (r_state)
         ST_RST:   w_state_nxt = ST_INIT;
         ST_INIT:  if (r_cnt == '1) w_state_nxt = ST_READY;
         ST_READY: begin
            w_busy  = 1'b0;
            w_ready = 1'b1;
         end
         default:  w_state_nxt = ST_RST;
      endcase
   end

   assign init_busy = w_busy;

   // Zero-extend then truncate so the index fits DATA_W whichever is wider.
   assign w_cnt_ext  = {{DATA_W{1'b0}}, r_cnt};
   assign w_init_val = (INIT_MODE == INIT_INDEX) ? w_cnt_ext[DATA_W-1:0] : '0;

   // ---------------- storage ----------------
   // The array itself is not reset: the init sweep rewrites every entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == ST_INIT) begin
         r_mem[r_cnt] <= w_init_val;
         r_cnt        <= r_cnt + 1'b1;
      end else if (w_ready) begin
         // Later ports are assigned last, so the highest index wins a collision.
         for (int j = 0; j < NUM_WR; j++) begin
            if (w_en_N[j] &&
                !((ZERO_REG != 0) && (w_address_d_N[j*ADDR_W +: ADDR_W] == '0)))
               r_mem[w_address_d_N[j*ADDR_W +: ADDR_W]] <= w_data_dval_N[j*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------- read ports ----------------
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .i_ready   (w_ready),
         .i_rd_addr (w_address_s_N[i*ADDR_W +: ADDR_W]),
         .i_mem     (r_mem),
`ifdef REGFILE_BYPASS_EN
         .i_wr_en   (w_en_N),
         .i_wr_addr (w_address_d_N),
         .i_wr_data (w_data_dval_N),
`endif
         .o_rd_data (w_data_sval_N[i*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   logic              clock;
   logic              reset;
   logic              init_busy;
   logic [NR*AW-1:0]  w_address_s_N;
   logic [NR*DW-1:0]  w_data_sval_N;
   logic [NW-1:0]     w_en_N;
   logic [NW*AW-1:0]  w_address_d_N;
   logic [NW*DW-1:0]  w_data_dval_N;

   register_file_mp #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
      .ZERO_REG(1), .INIT_MODE(1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .init_busy     (init_busy),
      .w_address_s_N (w_address_s_N),
      .w_data_sval_N (w_data_sval_N),
      .w_en_N        (w_en_N),
      .w_address_d_N (w_address_d_N),
      .w_data_dval_N (w_data_dval_N)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] exp;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      w_en_N        = we;
      w_address_d_N = {wa1, wa0};
      w_data_dval_N = {wd1, wd0};
      w_address_s_N = {ra1, ra0};
   endtask

   task automatic push(input string nm, input int p, input logic [31:0] e);
      sb_t s;
      s.name = nm; s.port = p; s.exp = e;
      sbq.push_back(s);
   endtask

   // Compare every pending expectation against the live read ports.
   task automatic drain();
      sb_t s;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         chk(s.name, w_data_sval_N[s.port*DW +: DW], s.exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Count cycles init_busy stays high after release; bounded.
   task automatic count_busy(input string nm, input int wr_at, output int n);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd4);
         if (!init_busy) break;
         n++;
         if (n == wr_at)
            drive(2'b01, 5'd4, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd5, 5'd4);
         if (n == 5) begin
            #3;
            chk({nm, "_rd_zero_in_init"}, w_data_sval_N[31:0], 32'h0);
         end
      end
      chk({nm, "_busy_cycles"}, 32'(n), 32'd32);
   endtask

   initial begin
      int nb;
      tbl[0]  = '{2'b01, 5'd7,  32'hDEAD_BEEF, 5'd0,  32'h0,         5'd5,  5'd31, 32'h5,         32'h1F};
      tbl[1]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd6,  32'hDEAD_BEEF, 32'h6};
      tbl[2]  = '{2'b01, 5'd0,  32'h1234_5678, 5'd0,  32'h0,         5'd0,  5'd31, 32'h0,         32'h1F};
      tbl[3]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd7,  32'h0,         32'hDEAD_BEEF};
      tbl[4]  = '{2'b11, 5'd9,  32'hAAAA_0000, 5'd9,  32'h5555_FFFF, 5'd10, 5'd8,  32'hA,         32'h8};
      tbl[5]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd9,  5'd0,  32'h5555_FFFF, 32'h0};
      tbl[6]  = '{2'b11, 5'd20, 32'h1111_1111, 5'd21, 32'h2222_2222, 5'd1,  5'd2,  32'h1,         32'h2};
      tbl[7]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd20, 5'd21, 32'h1111_1111, 32'h2222_2222};
      tbl[8]  = '{2'b10, 5'd0,  32'h0,         5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
      tbl[9]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd3,  32'h0,         32'h3};
      tbl[10] = '{2'b00, 5'd12, 32'h0000_0BAD, 5'd0,  32'h0,         5'd12, 5'd11, 32'hC,         32'hB};
      tbl[11] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd12, 5'd30, 32'hC,         32'h1E};

      // Reset held 3 cycles, then init sweep
      reset = 1'b1;
      drive(2'b01, 5'd4, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd5, 5'd4);
      tick(); tick(); tick();
      chk("rst_busy", {31'd0, init_busy}, 32'd1);
      chk("rst_rd0_zero", w_data_sval_N[31:0], 32'h0);
      chk("rst_rd1_zero", w_data_sval_N[63:32], 32'h0);
      reset = 1'b0;
      count_busy("init", -1, nb);
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd31);
      push("init_addr5", 0, 32'h5);
      push("init_addr31", 1, 32'h1F);
      @(negedge clock);
      drain();
      tick();

      // Table-driven READY traffic
      foreach (tbl[i]) begin
         drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1, tbl[i].ra0, tbl[i].ra1);
         push($sformatf("vec%0d_p0", i), 0, tbl[i].e0);
         push($sformatf("vec%0d_p1", i), 1, tbl[i].e1);
         @(negedge clock);
         drain();
         tick();
      end

      // Same-cycle read of the address being written
      drive(2'b01, 5'd3, 32'hCAFE_F00D, 5'd0, 32'h0, 5'd3, 5'd4);
`ifdef REGFILE_BYPASS_EN
      push("samecyc_rd", 0, 32'hCAFE_F00D);
`else
      push("samecyc_rd", 0, 32'h3);
`endif
      push("samecyc_other", 1, 32'h4);
      @(negedge clock);
      drain();
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0);
      push("nextcyc_rd", 0, 32'hCAFE_F00D);
      push("nextcyc_zero", 1, 32'h0);
      @(negedge clock);
      drain();
      tick();

      // Reset mid-operation, then reset again at init cycle 10
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 11; k++) tick();
      chk("midinit_busy", {31'd0, init_busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      count_busy("reinit", 20, nb);
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd7);
      push("reinit_addr4", 0, 32'h4);
      push("reinit_addr7", 1, 32'h7);
      @(negedge clock);
      drain();
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd3);
      push("reinit_addr9", 0, 32'h9);
      push("reinit_addr3", 1, 32'h3);
      @(negedge clock);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
